// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder: exception code,
// reset PC and FSM state encodings.
package imem_responder_pkg;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] INIT_PC  = 32'h0000_3000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/imem_responder_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one asynchronous
// write-first read port (a same-cycle write to the read index is forwarded).
module imem_responder_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = (we && (widx == ridx)) ? wdata : mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, returns the word after
// LATENCY cycles, flags AdEL on bad addresses and drops work on flush.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter logic [31:0] BASE    = INIT_PC,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    output logic                     req_ready,
    output logic                     stall,
    input  logic                     flush,
    output logic                     resp_valid,
    output logic [31:0]              resp_pc,
    output logic [31:0]              resp_instr,
    output logic                     resp_exc,
    output logic [4:0]               resp_exccode,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] LO_LIMIT = {1'b0, BASE};
    localparam logic [32:0] HI_LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [1:0]  ST_ACC   = (LATENCY == 1) ? ST_RESP : ST_WAIT;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [31:0] resp_instr_q, resp_instr_d;
    logic        resp_exc_q, resp_exc_d;
    logic [4:0]  resp_exccode_q, resp_exccode_d;

    logic          accept_c;
    logic          req_err_c;
    logic [32:0]   req_addr_ext_c;
    logic [AW-1:0] rd_idx_c;
    logic [31:0]   rd_data_c;

    // 33-bit compare so addresses near 2^32 cannot wrap into range
    assign req_addr_ext_c = {1'b0, req_addr};
    assign req_err_c = (req_addr[1:0] != 2'b00) ||
                       (req_addr_ext_c < LO_LIMIT) ||
                       (req_addr_ext_c >= HI_LIMIT);

    assign rd_idx_c = AW'((addr_q - BASE) >> 2);

    imem_responder_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ld_we),
        .widx  (ld_idx),
        .wdata (ld_data),
        .ridx  (rd_idx_c),
        .rdata (rd_data_c)
    );

    assign req_ready = (state_q != ST_WAIT);
    assign stall     = ~req_ready;

    // Next-state and response logic; flush overrides everything except a
    // simultaneous redirect request, which is taken as if from IDLE.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        err_d          = err_q;
        accept_c       = 1'b0;
        resp_valid_d   = 1'b0;
        resp_pc_d      = resp_pc_q;
        resp_instr_d   = resp_instr_q;
        resp_exc_d     = resp_exc_q;
        resp_exccode_d = resp_exccode_q;

        case (state_q)
            ST_IDLE: begin
                accept_c = req_valid;
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                accept_c = req_valid;
                state_d  = ST_IDLE;
                if (!flush) begin
                    resp_valid_d   = 1'b1;
                    resp_pc_d      = addr_q;
                    resp_instr_d   = err_q ? 32'd0 : rd_data_c;
                    resp_exc_d     = err_q;
                    resp_exccode_d = err_q ? EXC_ADEL : 5'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            accept_c = req_valid;
        end

        if (accept_c) begin
            state_d = ST_ACC;
            cnt_d   = CNT_INIT;
            addr_d  = req_addr;
            err_d   = req_err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            addr_q         <= 32'd0;
            err_q          <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_pc_q      <= 32'd0;
            resp_instr_q   <= 32'd0;
            resp_exc_q     <= 1'b0;
            resp_exccode_q <= 5'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            err_q          <= err_d;
            resp_valid_q   <= resp_valid_d;
            resp_pc_q      <= resp_pc_d;
            resp_instr_q   <= resp_instr_d;
            resp_exc_q     <= resp_exc_d;
            resp_exccode_q <= resp_exccode_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_pc      = resp_pc_q;
    assign resp_instr   = resp_instr_q;
    assign resp_exc     = resp_exc_q;
    assign resp_exccode = resp_exccode_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for single fetches,
// back-to-back, flush, reset and preload cases, plus a LATENCY=1 instance.
module tb_imem_responder;

    logic        clk;
    logic        reset;
    logic        ld_we;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    logic        req_valid, flush, req_ready, stall, resp_valid, resp_exc;
    logic [31:0] req_addr, resp_pc, resp_instr;
    logic [4:0]  resp_exccode;

    logic        req_valid1, flush1, req_ready1, stall1, resp_valid1, resp_exc1;
    logic [31:0] req_addr1, resp_pc1, resp_instr1;
    logic [4:0]  resp_exccode1;

    int checks = 0;
    int errors = 0;

    imem_responder #(.BASE(32'h0000_3000), .DEPTH(4096), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .stall(stall), .flush(flush),
        .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_instr(resp_instr),
        .resp_exc(resp_exc), .resp_exccode(resp_exccode),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    imem_responder #(.BASE(32'h0000_3000), .DEPTH(4096), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
        .stall(stall1), .flush(flush1),
        .resp_valid(resp_valid1), .resp_pc(resp_pc1), .resp_instr(resp_instr1),
        .resp_exc(resp_exc1), .resp_exccode(resp_exccode1),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_we = 1'b1; ld_idx = idx; ld_data = data;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Single fetch from IDLE on the LATENCY=2 instance.
    task automatic fetch_check(input string name, input logic [31:0] addr,
                               input logic exp_exc, input logic [31:0] exp_instr);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr;
        @(negedge clk);
        cyc = 1;
        req_valid = 1'b0;
        chk({name, " stall_in_wait"}, 32'(stall), 32'd1);
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd3);
        chk({name, " pc"}, resp_pc, addr);
        chk({name, " instr"}, resp_instr, exp_instr);
        chk({name, " exc"}, 32'(resp_exc), 32'(exp_exc));
        chk({name, " exccode"}, 32'(resp_exccode), exp_exc ? 32'd4 : 32'd0);
        @(negedge clk);
        chk({name, " one_cycle"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        exc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cyc;
        int seen;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins [3];
        logic exp_stall [5];
        logic exp_rv [5];

        vecs[0] = '{"idx0",     32'h0000_3000, 1'b0, 32'h3c01_1234};
        vecs[1] = '{"idx1",     32'h0000_3004, 1'b0, 32'h3421_5678};
        vecs[2] = '{"last",     32'h0000_6ffc, 1'b0, 32'hdead_beef};
        vecs[3] = '{"misalign", 32'h0000_3002, 1'b1, 32'h0};
        vecs[4] = '{"byte1",    32'h0000_3001, 1'b1, 32'h0};
        vecs[5] = '{"past_end", 32'h0000_7000, 1'b1, 32'h0};
        vecs[6] = '{"below",    32'h0000_2ffc, 1'b1, 32'h0};
        vecs[7] = '{"top4g",    32'hffff_fffc, 1'b1, 32'h0};
        exp_ins[0] = 32'h3c01_1234;
        exp_ins[1] = 32'h3421_5678;
        exp_ins[2] = 32'h2402_0003;
        exp_stall = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_rv    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; ld_we = 1'b0; ld_idx = '0; ld_data = '0;
        req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        req_valid1 = 1'b0; req_addr1 = '0; flush1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_pc", resp_pc, 32'd0);
        chk("rst resp_instr", resp_instr, 32'd0);
        chk("rst resp_exc", 32'(resp_exc), 32'd0);
        chk("rst resp_exccode", 32'(resp_exccode), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst l1 resp_valid", 32'(resp_valid1), 32'd0);
        reset = 1'b0;

        load(12'd0, 32'h3c01_1234);
        load(12'd1, 32'h3421_5678);
        load(12'd2, 32'h2402_0003);
        load(12'd1120, 32'h1234_5678);
        load(12'd4095, 32'hdead_beef);

        for (int i = 0; i < 8; i++) begin
            fetch_check(vecs[i].name, vecs[i].addr, vecs[i].exc, vecs[i].instr);
        end

        // Back-to-back: 0x3000 then held 0x3004.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) req_addr = 32'h0000_3004;
            chk($sformatf("b2b stall k%0d", k), 32'(stall), 32'(exp_stall[k]));
            chk($sformatf("b2b valid k%0d", k), 32'(resp_valid), 32'(exp_rv[k]));
            if (k == 2) begin
                req_valid = 1'b0;
                chk("b2b pc0", resp_pc, 32'h0000_3000);
                chk("b2b instr0", resp_instr, 32'h3c01_1234);
            end
            if (k == 4) begin
                chk("b2b pc1", resp_pc, 32'h0000_3004);
                chk("b2b instr1", resp_instr, 32'h3421_5678);
            end
        end

        // LATENCY=1: a response every cycle, stall never asserted.
        @(negedge clk);
        req_valid1 = 1'b1; req_addr1 = 32'h0000_3000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("l1 stall k%0d", k), 32'(stall1), 32'd0);
            if (k >= 2 && k <= 4) begin
                exp_pc = 32'h0000_3000 + 32'(4 * (k - 2));
                chk($sformatf("l1 valid k%0d", k), 32'(resp_valid1), 32'd1);
                chk($sformatf("l1 pc k%0d", k), resp_pc1, exp_pc);
                chk($sformatf("l1 instr k%0d", k), resp_instr1, exp_ins[k-2]);
            end else if (k == 5) begin
                chk("l1 valid end", 32'(resp_valid1), 32'd0);
            end
            if (k < 3) req_addr1 = req_addr1 + 32'd4;
            else req_valid1 = 1'b0;
        end

        // Flush in WAIT with redirect PC 0x4180.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        @(negedge clk);
        flush = 1'b1; req_addr = 32'h0000_4180;
        cyc = 0;
        seen = 0;
        @(negedge clk);
        cyc = 1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush kills valid", 32'(resp_valid), 32'd0);
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("flush latency", 32'(cyc), 32'd3);
        chk("flush pc", resp_pc, 32'h0000_4180);
        chk("flush instr", resp_instr, 32'h1234_5678);
        @(negedge clk);

        // Flush in RESP without a request: no response at all.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        chk("flush resp no output", 32'(seen), 32'd0);

        // Reset mid-WAIT after an error response left outputs non-zero.
        fetch_check("pre_reset", 32'h0000_3002, 1'b1, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3004;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw valid", 32'(resp_valid), 32'd0);
        chk("rstw pc", resp_pc, 32'd0);
        chk("rstw instr", resp_instr, 32'd0);
        chk("rstw exc", 32'(resp_exc), 32'd0);
        chk("rstw exccode", 32'(resp_exccode), 32'd0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rstw no stray", 32'(seen), 32'd0);

        // Preload write in the last WAIT cycle is visible.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3004;
        @(negedge clk);
        req_valid = 1'b0;
        ld_we = 1'b1; ld_idx = 12'd1; ld_data = 32'hcafe_f00d;
        @(negedge clk);
        ld_we = 1'b0;
        @(negedge clk);
        chk("ld wait valid", 32'(resp_valid), 32'd1);
        chk("ld wait instr", resp_instr, 32'hcafe_f00d);

        // Write in the same cycle as the read returns the new word.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3004;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ld_we = 1'b1; ld_idx = 12'd1; ld_data = 32'h0bad_c0de;
        @(negedge clk);
        ld_we = 1'b0;
        chk("ld same valid", 32'(resp_valid), 32'd1);
        chk("ld same instr", resp_instr, 32'h0bad_c0de);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
